// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows byte rotation of one 32-bit state row.
// Latency: zero (combinational row_out/done while start=1); registered copy updates next edge.
// Backpressure: none; every start cycle is accepted independently, back-to-back allowed.
//
// Ports:
//   clk      rising-edge clock for the hold register
//   rst      synchronous active-high reset; clears the hold register, wins over start
//   idx_row  row number 0..3, equals rotation amount in bytes
//   row_in   input row, byte 0 (leftmost column) in [31:24]
//   start    request strobe; row_in/idx_row valid this cycle
//   done     high in the same cycle as start
//   row_out  rotated row while start=1, otherwise the last captured result
module shift_rows #(
    parameter bit INVERSE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  idx_row,
    input  logic [31:0] row_in,
    input  logic        start,
    output logic        done,
    output logic [31:0] row_out
);

    logic [1:0]  rot_amt;
    logic [31:0] row_rot;
    logic [31:0] row_q;

    // A right rotation by n bytes is a left rotation by (4 - n) mod 4, so the
    // inverse build only remaps the amount and shares the left-rotate wiring.
    always_comb begin
        rot_amt = idx_row;
        if (INVERSE) begin
            rot_amt = 2'd0 - idx_row;
        end
    end

    // Left rotation by whole bytes: pure wiring, no byte is altered.
    always_comb begin
        row_rot = row_in;
        case (rot_amt)
            2'd0: row_rot = row_in;
            2'd1: row_rot = {row_in[23:0], row_in[31:24]};
            2'd2: row_rot = {row_in[15:0], row_in[31:16]};
            2'd3: row_rot = {row_in[7:0],  row_in[31:8]};
            default: row_rot = row_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= 32'h0;
        end else if (start) begin
            row_q <= row_rot;
        end
    end

    // When idle, idx_row is don't-care: the mux picks row_q so an unknown
    // index cannot leak onto row_out.
    always_comb begin
        done    = start;
        row_out = start ? row_rot : row_q;
    end

endmodule

// File: tb/tb_shift_rows.sv
module tb_shift_rows;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  idx_row = 2'd0;
    logic [31:0] row_in = 32'h0;
    logic        start = 1'b0;
    logic        done_fwd, done_inv;
    logic [31:0] out_fwd, out_inv;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    shift_rows #(.INVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst(rst), .idx_row(idx_row), .row_in(row_in),
        .start(start), .done(done_fwd), .row_out(out_fwd)
    );

    shift_rows #(.INVERSE(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .idx_row(idx_row), .row_in(row_in),
        .start(start), .done(done_inv), .row_out(out_inv)
    );

    // Reference: output column i takes input column (i + shift) mod 4,
    // shift = idx for forward, (4 - idx) mod 4 for inverse.
    function automatic logic [31:0] ref_rot(input logic [31:0] w, input int idx, input bit inv);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          sh;
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        sh = inv ? ((4 - idx) % 4) : idx;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[31-8*i -: 8] = b[(i + sh) % 4];
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; row_in = $urandom; idx_row = 2'($urandom);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (out_fwd !== 32'h0) $display("FAIL reset_fwd_out got=%h exp=%h", out_fwd, 32'h0);
        else n_pass++;
        n_total++;
        if (out_inv !== 32'h0) $display("FAIL reset_inv_out got=%h exp=%h", out_inv, 32'h0);
        else n_pass++;
        n_total++;
        if (done_fwd !== 1'b0 || done_inv !== 1'b0)
            $display("FAIL reset_done got=%b%b exp=00", done_fwd, done_inv);
        else n_pass++;
    endtask

    task automatic test_forward_vectors();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h00112233; exp_tab[1] = 32'h11223300;
        exp_tab[2] = 32'h22330011; exp_tab[3] = 32'h33001122;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1; row_in = 32'h00112233; idx_row = 2'(k);
            #1;
            n_total++;
            if (out_fwd !== exp_tab[k] || done_fwd !== 1'b1)
                $display("FAIL fwd_vec idx=%0d got=%h/%b exp=%h/1", k, out_fwd, done_fwd, exp_tab[k]);
            else n_pass++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        start = 1'b1; idx_row = 2'd1; row_in = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; row_in = $urandom;
        for (int c = 0; c < 3; c++) begin
            idx_row = 2'($urandom);
            #1;
            n_total++;
            if (out_fwd !== 32'hADBEEFDE || done_fwd !== 1'b0)
                $display("FAIL hold_fwd cyc=%0d got=%h/%b exp=adbeefde/0", c, out_fwd, done_fwd);
            else n_pass++;
            n_total++;
            if (out_inv !== 32'hEFDEADBE || done_inv !== 1'b0)
                $display("FAIL hold_inv cyc=%0d got=%h/%b exp=efdeadbe/0", c, out_inv, done_inv);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        start = 1'b1; rst = 1'b1; row_in = 32'h01020304; idx_row = 2'd2;
        #1;
        n_total++;
        if (out_fwd !== 32'h03040102 || done_fwd !== 1'b1)
            $display("FAIL rstpri_comb got=%h/%b exp=03040102/1", out_fwd, done_fwd);
        else n_pass++;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        #1;
        n_total++;
        if (out_fwd !== 32'h0 || out_inv !== 32'h0)
            $display("FAIL rstpri_hold got=%h,%h exp=00000000", out_fwd, out_inv);
        else n_pass++;
    endtask

    task automatic test_inverse();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h00112233; exp_tab[1] = 32'h33001122;
        exp_tab[2] = 32'h22330011; exp_tab[3] = 32'h11223300;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1; row_in = 32'h00112233; idx_row = 2'(k);
            #1;
            n_total++;
            if (out_inv !== exp_tab[k] || done_inv !== 1'b1)
                $display("FAIL inv_vec idx=%0d got=%h/%b exp=%h/1", k, out_inv, done_inv, exp_tab[k]);
            else n_pass++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'hA0B1C2D3; exp_tab[1] = 32'hB1C2D3A0;
        exp_tab[2] = 32'hC2D3A0B1; exp_tab[3] = 32'hD3A0B1C2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1; row_in = 32'hA0B1C2D3; idx_row = 2'(k);
            #1;
            n_total++;
            if (out_fwd !== exp_tab[k])
                $display("FAIL b2b_fwd idx=%0d got=%h exp=%h", k, out_fwd, exp_tab[k]);
            else n_pass++;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_total++;
        if (out_fwd !== 32'hD3A0B1C2 || done_fwd !== 1'b0)
            $display("FAIL b2b_hold_fwd got=%h/%b exp=d3a0b1c2/0", out_fwd, done_fwd);
        else n_pass++;
        n_total++;
        if (out_inv !== 32'hB1C2D3A0)
            $display("FAIL b2b_hold_inv got=%h exp=b1c2d3a0", out_inv);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] q_fwd, q_inv, e_fwd, e_inv;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q_fwd = 32'h0; q_inv = 32'h0;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 9) == 0);
            row_in  = $urandom;
            idx_row = 2'($urandom);
            #1;
            e_fwd = start ? ref_rot(row_in, int'(idx_row), 1'b0) : q_fwd;
            e_inv = start ? ref_rot(row_in, int'(idx_row), 1'b1) : q_inv;
            n_total++;
            if (out_fwd !== e_fwd) $display("FAIL rnd_fwd it=%0d got=%h exp=%h", it, out_fwd, e_fwd);
            else n_pass++;
            n_total++;
            if (out_inv !== e_inv) $display("FAIL rnd_inv it=%0d got=%h exp=%h", it, out_inv, e_inv);
            else n_pass++;
            n_total++;
            if (done_fwd !== start || done_inv !== start)
                $display("FAIL rnd_done it=%0d got=%b%b exp=%b", it, done_fwd, done_inv, start);
            else n_pass++;
            @(posedge clk);
            if (rst) begin
                q_fwd = 32'h0; q_inv = 32'h0;
            end else if (start) begin
                q_fwd = e_fwd; q_inv = e_inv;
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_vectors();
        test_hold();
        test_reset_priority();
        test_inverse();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_rows.md
Name: shift_rows

Overview:
- Performs the AES ShiftRows byte rotation on one 32-bit state row at a time.
- The row index selects the rotation amount.
- Sits in the AES-128 round datapath between SubBytes and MixColumns; the round controller iterates rows 0..3.
- Zero-latency combinational result path, plus a registered copy that holds the last result between requests.

Parameters:
- INVERSE, default 0. 0 = forward ShiftRows (rotate left by idx_row bytes). 1 = InvShiftRows (rotate right by idx_row bytes).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- idx_row  input  2  row number 0..3; equals the rotation amount in bytes.
- row_in  input  32  input row; byte 0 (leftmost state column) is row_in[31:24], byte 3 is row_in[7:0].
- start  input  1  request strobe; when high, row_in/idx_row are valid this cycle.
- done  output  1  result-valid indication.
- row_out  output  32  rotated row, same byte ordering as row_in.

Behaviour:
- Byte view: B0=row_in[31:24], B1=[23:16], B2=[15:8], B3=[7:0].
- Forward (INVERSE=0), row_out by idx_row:
  - 0: B0 B1 B2 B3 (no shift)
  - 1: B1 B2 B3 B0
  - 2: B2 B3 B0 B1
  - 3: B3 B0 B1 B2
- Inverse (INVERSE=1), row_out by idx_row:
  - 0: unchanged
  - 1: B3 B0 B1 B2
  - 2: B2 B3 B0 B1
  - 3: B1 B2 B3 B0
- Rotation is pure byte wiring; no arithmetic; bytes are never altered or reordered within themselves.
- Combinational path: while start=1, row_out = rotation of the current row_in/idx_row, and done=1 in the same cycle (zero latency). The result is valid after combinational settling, with no clock edge required.
- Hold register row_q (32 bits):
  - Loads the rotated value on the rising clk edge when start=1 and rst=0.
  - Holds otherwise.
- While start=0: row_out = row_q and done = 0.
- Reset: on a rising clk edge with rst=1, row_q is cleared to 32'h0. rst has priority over a simultaneous start for the register update. The combinational path still reflects start/row_in during a reset cycle, so done=start regardless of rst.
- After reset with start=0: row_out = 32'h00000000, done = 0.
- Back-to-back start cycles are allowed; each cycle is independent, with no busy state and no back-pressure.
- Changing idx_row/row_in mid-cycle while start=1: outputs follow combinationally; the register captures the values present at the clock edge.
- No X propagation from idx_row when start=0: idx_row is don't-care and row_out shows row_q.

Test Plan:
- Forward, start=1, row_in=32'h00112233, idx_row=0/1/2/3 -> row_out=00112233 / 11223300 / 22330011 / 33001122, done=1, each checked 1 ns after applying inputs (no clock edge).
- Reset then idle: rst=1 for one edge, start=0 -> row_out=00000000, done=0.
- Hold: start=1, idx_row=1, row_in=DEADBEEF, clock edge; then start=0 -> done=0, row_out=ADBEEFDE retained over several cycles.
- Reset priority: start=1, rst=1, row_in=01020304, idx_row=2, edge; then start=0 -> row_out=00000000.
- Inverse build (INVERSE=1), row_in=00112233, idx_row=1/3 -> 33001122 / 11223300; idx_row=2 -> 22330011.
- Back-to-back: start held high across 4 edges, idx_row stepping 0..3, row_in=A0B1C2D3 -> each cycle row_out = A0B1C2D3, B1C2D3A0, C2D3A0B1, D3A0B1C2; after start drops, row_out holds D3A0B1C2.
